// File: rtl/rgb_contrast.sv
// Contrast stage for the RGB pixel chain: per-channel gain about mid-grey (128)
// with clamping, a bypass mode, and a saturating count of clipped pixels.
module rgb_contrast #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           r_in,
    input  logic [7:0]           g_in,
    input  logic [7:0]           b_in,
    input  logic                 data_valid,
    input  logic [7:0]           contrast_level,
    input  logic                 contrast_enable,
    input  logic                 stat_clear,
    output logic [7:0]           r_out,
    output logic [7:0]           g_out,
    output logic [7:0]           b_out,
    output logic                 data_out_valid,
    output logic [CNT_WIDTH-1:0] clip_count
);

    // Handshake: a valid flag qualifies its stage data for exactly one cycle;
    // there is no ready, so every stage advances each cycle and never stalls.
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [7:0] pix_in [3];

    // Stage 1: centred channel values plus the gain settings that travel with them
    logic              v1;
    logic              en1;
    logic [7:0]        lvl1;
    logic signed [8:0] d1 [3];

    // Stage 2: full-precision products and the untouched pixel for bypass
    logic               v2;
    logic               en2;
    logic signed [17:0] p2   [3];
    logic [7:0]         byp2 [3];

    // Stage 3: clamped result and clip flag, one flop layer before the outputs
    logic       v3;
    logic       clip3;
    logic [7:0] q3 [3];

    logic [7:0] q3_n [3];
    logic       clip3_n;

    function automatic logic [8:0] scale_ch(input logic signed [17:0] p);
        logic signed [11:0] s;
        s = 12'(p >>> 7) + 12'sd128;
        if (s < 12'sd0)
            return {1'b1, 8'd0};
        else if (s > 12'sd255)
            return {1'b1, 8'd255};
        else
            return {1'b0, s[7:0]};
    endfunction

    always_comb begin
        pix_in[0] = r_in;
        pix_in[1] = g_in;
        pix_in[2] = b_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            en1  <= 1'b0;
            lvl1 <= '0;
            for (int i = 0; i < 3; i++) d1[i] <= '0;
        end else begin
            v1 <= data_valid;
            if (data_valid) begin
                en1  <= contrast_enable;
                lvl1 <= contrast_level;
                for (int i = 0; i < 3; i++)
                    d1[i] <= $signed({1'b0, pix_in[i]}) - 9'sd128;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            en2 <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                p2[i]   <= '0;
                byp2[i] <= '0;
            end
        end else begin
            v2 <= v1;
            if (v1) begin
                en2 <= en1;
                for (int i = 0; i < 3; i++) begin
                    p2[i]   <= 18'(d1[i]) * 18'($signed({1'b0, lvl1}));
                    byp2[i] <= d1[i][7:0] ^ 8'h80;
                end
            end
        end
    end

    always_comb begin
        clip3_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [8:0] sc;
            sc = scale_ch(p2[i]);
            if (en2) begin
                q3_n[i] = sc[7:0];
                clip3_n = clip3_n | sc[8];
            end else begin
                q3_n[i] = byp2[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3    <= 1'b0;
            clip3 <= 1'b0;
            for (int i = 0; i < 3; i++) q3[i] <= '0;
        end else begin
            v3 <= v2;
            if (v2) begin
                clip3 <= clip3_n;
                for (int i = 0; i < 3; i++) q3[i] <= q3_n[i];
            end
        end
    end

    // Output layer: holds the last pixel between valid pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_valid <= 1'b0;
            r_out          <= '0;
            g_out          <= '0;
            b_out          <= '0;
        end else begin
            data_out_valid <= v3;
            if (v3) begin
                r_out <= q3[0];
                g_out <= q3[1];
                b_out <= q3[2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clip_count <= '0;
        else if (stat_clear)
            clip_count <= '0;
        else if (v3 && clip3 && clip_count != CNT_MAX)
            clip_count <= clip_count + CNT_WIDTH'(1);
    end

endmodule
